i2s_tx_fifo: RTL and testbench
==============================

// Module: i2s_tx_fifo
// PURPOSE
// Parametrised I2S/TDM serial audio transmitter with an on-chip frame FIFO.
// Accepts multi-channel frames over a valid/ready handshake, buffers them, and
// serialises them as sclk/lrclk/sd. Supports I2S or left-justified format.
// Runs entirely in the audio master-clock domain; the upstream CDC feeds frame_*.
// PARAMETERS
// DATA_BIT        16  sample width per channel
// SLOT_BIT        32  sclk periods per channel slot; must be >= DATA_BIT
// NUM_CH          2   channels per frame; even; 2 = stereo I2S, >2 = TDM
// MCLK_SCLK_RATIO 8   clk cycles per sclk period; power of two, >= 2
// FIFO_DEPTH      4   frames buffered; power of two
// FORMAT          0   0 = I2S (MSB one sclk after lrclk edge), 1 = left-justified
// PORTS
// clk          in   1                        audio master clock (e.g. 24.576 MHz)
// reset        in   1                        asynchronous, active-high
// enable       in   1                        run request
// frame_data   in   NUM_CH*DATA_BIT          ch0 in MSBs
// frame_valid  in   1                        frame_data valid
// frame_ready  out  1                        ~reset & ~fifo_full
// fifo_level   out  $clog2(FIFO_DEPTH+1)     frames held
// underrun     out  1                        1-clk pulse: frame boundary with empty FIFO
// tx_mclk      out  1                        clk & ~reset
// tx_sclk      out  1                        serial bit clock
// tx_lrclk     out  1                        word select / frame sync
// tx_sd        out  1                        serial data
// BEHAVIOUR
// - Reset: FIFO flushed, state IDLE, counters 0; sclk/lrclk/sd/underrun = 0.
// - Push on frame_valid & frame_ready. No push when full. No empty bypass.
// - FSM: IDLE -> PRIME when enable=1. PRIME -> RUN when fifo_level != 0.
//   RUN -> STOPPING when enable=0. STOPPING -> IDLE at frame end.
//   STOPPING -> RUN if enable returns before frame end.
// - Clocks in IDLE and PRIME: sclk=lrclk=sd=0; tx_mclk keeps running.
// - RUN entry clk: div=0, bit_cnt=0; FIFO head popped into shift reg.
// - div counts 0..MCLK_SCLK_RATIO-1; sclk = (div >= RATIO/2), so low half first.
//   Falling edge = div wrap. At a wrap, bit_cnt increments mod NUM_CH*SLOT_BIT.
//   The shift register also shifts left, MSB first.
// - Shift reg: per slot, DATA_BIT sample bits then SLOT_BIT-DATA_BIT zeros.
// - lrclk = (bit_cnt >= NUM_CH*SLOT_BIT/2), registered; changes on sclk fall.
// - FORMAT=1: sd = shift MSB; frame MSB coincides with lrclk falling edge.
// - FORMAT=0: sd passes through 1 extra flop clocked at each sclk fall.
//   The MSB appears 1 sclk after the lrclk edge.
//   The last bit of a frame spills into bit 0 of the next frame.
// - Frame boundary = wrap with bit_cnt = NUM_CH*SLOT_BIT-1. The next frame loads
//   on that clk. If the FIFO is empty, zeros load and underrun pulses.
//   Simultaneous push and pop on a boundary is legal; level is unchanged.
// - sd/lrclk change only on sclk fall, so they are stable at sclk rise.
// - enable low mid-frame: the current frame completes; FIFO contents are kept.
// - reset mid-frame: outputs drop to 0 asynchronously. No partial frame resumes.
// STRUCTURE
// - Package i2s_pkg: i2s_format_e {I2S_STD, I2S_LJ}, i2s_tx_state_e
//   {IDLE, PRIME, RUN, STOPPING}, localparams FRAME_BIT = NUM_CH*SLOT_BIT.
// - Sub-module i2s_frame_fifo: single-clock FIFO, width NUM_CH*DATA_BIT,
//   depth FIFO_DEPTH, with full/empty/level outputs.
// - Top: FSM, div/bit_cnt counters, shift register, I2S delay flop.
// TESTING
// - Defaults, FORMAT=1: push {A5F0,0F0F}, enable.
//   -> sd bits 0-15 = A5F0 MSB first, bits 16-31 = 0, lrclk=0.
//   -> bits 32-47 = 0F0F, lrclk=1. sclk period 8 clk.
// - FORMAT=0, SLOT_BIT=16: push {8001,8001}, then {0000,0000}.
//   -> MSB 1 sclk after each lrclk edge.
//   -> ch1 LSB=1 appears at bit 0 of frame 2.
// - Underrun: push 1 frame, enable, no more pushes.
//   -> frame 2 all zeros; underrun one 1-clk pulse per boundary; fifo_level=0.
// - Backpressure: enable=0, frame_valid held, 5 frames offered.
//   -> 4 accepted, level=4, frame_ready=0.
//   -> 5th accepted on the clk after the first pop in RUN.
// - Stop: deassert enable at bit 10 -> frame finishes through bit 63.
//   -> then sclk/lrclk/sd=0, IDLE, level retained.
// - Async reset asserted mid-frame -> outputs 0 with no clk edge, level=0.
//   -> after release, a new frame transmits from bit 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and frame-size helpers for the I2S/TDM transmitter
package i2s_pkg;
    typedef enum logic {I2S_STD, I2S_LJ} i2s_format_e;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, STOPPING} i2s_tx_state_e;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_SLOT_BIT = 32;
    localparam int FRAME_BIT = DEF_NUM_CH * DEF_SLOT_BIT;
    function automatic int frame_bits(input int num_ch, input int slot_bit);
        return num_ch * slot_bit;
    endfunction
endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: single-clock frame FIFO (push/pop, full/empty/level); async active-high reset flushes it
module i2s_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_en ? inc(wr_ptr) : wr_ptr;
            rd_ptr <= rd_en ? inc(rd_ptr) : rd_ptr;
            level  <= level + LW'(wr_en) - LW'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: I2S/left-justified/TDM serialiser fed by a frame FIFO; frame_* handshake in, tx_* serial out, fifo_level/underrun status
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int DATA_BIT        = 16,
    parameter int SLOT_BIT        = 32,
    parameter int NUM_CH          = 2,
    parameter int MCLK_SCLK_RATIO = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int FORMAT          = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_CH*DATA_BIT-1:0]         frame_data,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               underrun,
    output logic                               tx_mclk,
    output logic                               tx_sclk,
    output logic                               tx_lrclk,
    output logic                               tx_sd
);
    localparam int N_BIT = frame_bits(NUM_CH, SLOT_BIT);
    localparam int FW = NUM_CH * DATA_BIT;
    localparam int DW = (MCLK_SCLK_RATIO > 1) ? $clog2(MCLK_SCLK_RATIO) : 1;
    localparam int BW = $clog2(N_BIT);
    localparam bit LJ = (FORMAT == int'(I2S_LJ));
    i2s_tx_state_e state, state_n;
    logic [DW-1:0] div;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [N_BIT-1:0] shift, frame_fmt;
    logic [FW-1:0] fifo_dout;
    logic fifo_full, fifo_empty, sd_d, lrclk_q, underrun_q;
    logic active, wrap, frame_end, start, load;
    i2s_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (frame_valid & frame_ready),
        .pop   (load),
        .din   (frame_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );
    // each slot carries its sample left-aligned with zero padding below
    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        assign frame_fmt[N_BIT-1-c*SLOT_BIT -: SLOT_BIT] =
            SLOT_BIT'(fifo_dout[FW-1-c*DATA_BIT -: DATA_BIT]) << (SLOT_BIT - DATA_BIT);
    end
    assign active    = state == RUN || state == STOPPING;
    assign wrap      = active && div == DW'(MCLK_SCLK_RATIO - 1);
    assign frame_end = wrap && bit_cnt == BW'(N_BIT - 1);
    assign bit_nxt   = (bit_cnt == BW'(N_BIT - 1)) ? '0 : bit_cnt + BW'(1);
    assign start     = state == PRIME && state_n == RUN;
    assign load      = start || (frame_end && state_n == RUN);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = enable ? PRIME : IDLE;
            PRIME:    state_n = !enable ? IDLE : (fifo_level != '0) ? RUN : PRIME;
            RUN:      state_n = enable ? RUN : frame_end ? IDLE : STOPPING;
            STOPPING: state_n = enable ? RUN : frame_end ? IDLE : STOPPING;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            sd_d       <= 1'b0;
            lrclk_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_n;
            underrun_q <= load && fifo_empty;
            if (start) begin
                div     <= '0;
                bit_cnt <= '0;
                shift   <= frame_fmt;
                sd_d    <= 1'b0;
                lrclk_q <= 1'b0;
            end else if (active) begin
                div <= wrap ? '0 : div + DW'(1);
                if (wrap) begin
                    bit_cnt <= bit_nxt;
                    shift   <= load ? (fifo_empty ? '0 : frame_fmt) : shift << 1;
                    // I2S delay flop: each bit reappears one sclk later, so the
                    // last bit of a frame lands in bit 0 of the next one
                    sd_d    <= shift[N_BIT-1];
                    lrclk_q <= bit_nxt >= BW'(N_BIT / 2);
                end
            end else begin
                div     <= '0;
                bit_cnt <= '0;
                sd_d    <= 1'b0;
                lrclk_q <= 1'b0;
            end
        end
    end
    assign frame_ready = ~reset & ~fifo_full;
    assign underrun    = underrun_q;
    assign tx_mclk     = clk & ~reset;
    assign tx_sclk     = active && div >= DW'(MCLK_SCLK_RATIO / 2);
    assign tx_lrclk    = lrclk_q;
    assign tx_sd       = active && (LJ ? shift[N_BIT-1] : sd_d);
endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: directed checks of a left-justified (a_) and an I2S 16-bit-slot (b_) transmitter
module tb_i2s_tx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic a_en = 0, a_valid = 0, b_en = 0, b_valid = 0;
    logic [31:0] a_data = '0, b_data = '0;
    logic a_ready, a_ur, a_mclk, a_sclk, a_lrclk, a_sd;
    logic b_ready, b_ur, b_mclk, b_sclk, b_lrclk, b_sd;
    logic [2:0] a_level, b_level;
    i2s_tx_fifo #(.FORMAT(1)) u_a (
        .clk(clk), .reset(reset), .enable(a_en), .frame_data(a_data), .frame_valid(a_valid),
        .frame_ready(a_ready), .fifo_level(a_level), .underrun(a_ur), .tx_mclk(a_mclk),
        .tx_sclk(a_sclk), .tx_lrclk(a_lrclk), .tx_sd(a_sd)
    );
    i2s_tx_fifo #(.SLOT_BIT(16), .FORMAT(0)) u_b (
        .clk(clk), .reset(reset), .enable(b_en), .frame_data(b_data), .frame_valid(b_valid),
        .frame_ready(b_ready), .fifo_level(b_level), .underrun(b_ur), .tx_mclk(b_mclk),
        .tx_sclk(b_sclk), .tx_lrclk(b_lrclk), .tx_sd(b_sd)
    );
    logic [0:511] a_sdc = '0, a_lrc = '0, b_sdc = '0, b_lrc = '0;
    logic a_sq = 0, b_sq = 0;
    int a_cnt = 0, b_cnt = 0, ur_cnt = 0;
    int a_base = 0, b_base = 0;
    int n_chk = 0, n_pass = 0;
    // record sd/lrclk at every sclk rise, sampled on the falling clk edge
    always @(negedge clk) begin
        a_sq <= a_sclk;
        b_sq <= b_sclk;
        if (a_sclk && !a_sq && a_cnt < 512) begin
            a_sdc[a_cnt] <= a_sd;
            a_lrc[a_cnt] <= a_lrclk;
            a_cnt <= a_cnt + 1;
        end
        if (b_sclk && !b_sq && b_cnt < 512) begin
            b_sdc[b_cnt] <= b_sd;
            b_lrc[b_cnt] <= b_lrclk;
            b_cnt <= b_cnt + 1;
        end
        if (a_ur)
            ur_cnt <= ur_cnt + 1;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask
    task automatic wait_bits(input bit b, input int n);
        int k;
        for (k = 0; k < 4000 && (b ? b_cnt - b_base : a_cnt - a_base) < n; k++) begin
            @(negedge clk);
            #1;
        end
        if ((b ? b_cnt - b_base : a_cnt - a_base) < n)
            check(b ? "b_bit_timeout" : "a_bit_timeout", 64'(b ? b_cnt - b_base : a_cnt - a_base), 64'(n));
    endtask
    task automatic push(input bit b, input logic [31:0] d);
        if (b) begin b_data = d; b_valid = 1; end
        else begin a_data = d; a_valid = 1; end
        @(posedge clk);
        #1;
        a_valid = 0;
        b_valid = 0;
    endtask
    logic [31:0] fr [5] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0001_8000, 32'hFFFF_FFFF, 32'h5A5A_C3C3};
    int per;
    bit seen;
    initial begin
        #12;
        check("rst_ready", a_ready, 0);
        check("rst_outs", {a_sclk, a_lrclk, a_sd, a_ur}, 0);
        check("rst_level", a_level, 0);
        @(negedge clk);
        reset = 0;
        #1;
        check("ready_after_rst", a_ready, 1);
        // I2S, 16-bit slots: delayed MSB and spill into the next frame
        push(1, 32'h8001_8001);
        push(1, 32'h0000_0000);
        check("b_level2", b_level, 2);
        b_base = b_cnt;
        b_en = 1;
        wait_bits(1, 64);
        b_en = 0;
        check("b_sd", b_sdc[b_base +: 64], 64'h4000_C000_8000_0000);
        check("b_lrclk", b_lrc[b_base +: 64], 64'h0000_FFFF_0000_FFFF);
        check("b_spill", b_sdc[b_base + 32], 1);
        // left-justified, then two underrun frames
        push(0, 32'hA5F0_0F0F);
        check("a_level1", a_level, 1);
        a_base = a_cnt;
        a_en = 1;
        wait_bits(0, 1);
        per = 0;
        while (a_cnt - a_base < 2 && per < 100) begin
            @(negedge clk);
            #1;
            per++;
        end
        check("sclk_period", per, 8);
        wait_bits(0, 192);
        a_en = 0;
        check("lj_sd", a_sdc[a_base +: 64], 64'hA5F0_0000_0F0F_0000);
        check("lj_lrclk", a_lrc[a_base +: 64], 64'h0000_0000_FFFF_FFFF);
        check("ur_frame2_sd", a_sdc[a_base + 64 +: 64], 0);
        check("ur_frame3_sd", a_sdc[a_base + 128 +: 64], 0);
        check("ur_frame2_lrclk", a_lrc[a_base + 64 +: 64], 64'h0000_0000_FFFF_FFFF);
        repeat (40) @(negedge clk);
        #1;
        check("ur_pulses", ur_cnt, 2);
        check("ur_level", a_level, 0);
        check("idle_outs", {a_sclk, a_lrclk, a_sd}, 0);
        check("idle_no_more_bits", a_cnt - a_base, 192);
        // backpressure with enable low
        a_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_data = fr[i];
            @(posedge clk);
            #1;
        end
        a_data = fr[4];
        repeat (6) @(negedge clk);
        #1;
        check("bp_level_full", a_level, 4);
        check("bp_ready_low", a_ready, 0);
        a_base = a_cnt;
        a_en = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = a_level == 3;
        end
        check("bp_pop_level", a_level, 3);
        check("bp_ready_after_pop", a_ready, 1);
        @(negedge clk);
        #1;
        check("bp_fifth_accepted", a_level, 4);
        a_valid = 0;
        // drop enable at bit 10; the frame must still complete
        wait_bits(0, 11);
        a_en = 0;
        wait_bits(0, 64);
        repeat (40) @(negedge clk);
        #1;
        check("stop_bit_count", a_cnt - a_base, 64);
        check("stop_sd", a_sdc[a_base +: 64], 64'h1234_0000_5678_0000);
        check("stop_level_kept", a_level, 4);
        check("stop_outs", {a_sclk, a_lrclk, a_sd}, 0);
        // asynchronous reset mid-frame
        a_base = a_cnt;
        a_en = 1;
        wait_bits(0, 41);
        check("pre_rst_outs", {a_sclk, a_lrclk, a_sd}, 3'b111);
        #2;
        reset = 1;
        #1;
        check("async_rst_outs", {a_sclk, a_lrclk, a_sd}, 0);
        check("async_rst_level", a_level, 0);
        check("async_rst_ready", a_ready, 0);
        @(negedge clk);
        reset = 0;
        a_base = a_cnt;
        push(0, 32'hC001_8003);
        wait_bits(0, 64);
        a_en = 0;
        check("post_rst_sd", a_sdc[a_base +: 64], 64'hC001_0000_8003_0000);
        check("post_rst_lrclk", a_lrc[a_base +: 64], 64'h0000_0000_FFFF_FFFF);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
